// File: rtl/filter_cascade.sv
// Six cascaded second-order all-pole sections evaluated serially through a single
// multiplier; one filtered sample is produced per rising edge of the strobe.
module filter_cascade #(
    parameter int unsigned NSECT = 6,
    parameter int unsigned CW    = 10
) (
    input  logic          clk,
    input  logic          rst_an,
    input  logic [15:0]   source_in,
    input  logic          strobe,
    input  logic [CW-1:0] coef_in,
    input  logic [3:0]    coef_addr,
    input  logic          coef_we,
    input  logic          clear,
    output logic [15:0]   sample_out,
    output logic          sample_valid,
    output logic          busy
);

    localparam int unsigned SW   = (NSECT > 1) ? $clog2(NSECT) : 1;
    localparam int unsigned ACCW = 28;
    localparam int unsigned PW   = CW + 16;

    typedef enum logic [1:0] {Idle, MacA, MacB, Write} state_e;

    state_e state_q, state_d;

    logic                   last_strobe_q;
    logic                   strobe_edge;
    logic        [SW-1:0]   sect_q;
    logic signed [15:0]     x_q;
    logic signed [ACCW-1:0] acc_q;
    logic signed [15:0]     sample_out_q;
    logic                   sample_valid_q;

    logic signed [CW-1:0]   c1_q [NSECT];
    logic signed [CW-1:0]   c2_q [NSECT];
    logic signed [15:0]     d1_q [NSECT];
    logic signed [15:0]     d2_q [NSECT];

    logic                   last_sect;
    logic signed [CW-1:0]   mul_a;
    logic signed [15:0]     mul_b;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc_shifted;
    logic signed [15:0]     y_sat;

    assign strobe_edge = strobe & ~last_strobe_q;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Idle:    if (strobe_edge) state_d = MacA;
            MacA:    state_d = MacB;
            MacB:    state_d = Write;
            Write:   state_d = last_sect ? Idle : MacA;
            default: state_d = Idle;
        endcase
    end

    // MAC_B works on the c2/d2 pair, every other state presents c1/d1 to the multiplier.
    always_comb begin
        busy      = (state_q != Idle);
        last_sect = (sect_q == SW'(NSECT - 1));
        mul_a     = c1_q[sect_q];
        mul_b     = d1_q[sect_q];
        if (state_q == MacB) begin
            mul_a = c2_q[sect_q];
            mul_b = d2_q[sect_q];
        end
    end

    assign prod        = mul_a * mul_b;
    assign acc_shifted = acc_q >>> 9;

    always_comb begin
        y_sat = acc_shifted[15:0];
        if (acc_shifted > ACCW'(32767)) begin
            y_sat = 16'sh7fff;
        end else if (acc_shifted < -ACCW'(32768)) begin
            y_sat = 16'sh8000;
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            last_strobe_q  <= 1'b0;
            sect_q         <= '0;
            x_q            <= '0;
            acc_q          <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            for (int k = 0; k < NSECT; k++) begin
                c1_q[k] <= '0;
                c2_q[k] <= '0;
                d1_q[k] <= '0;
                d2_q[k] <= '0;
            end
        end else begin
            last_strobe_q  <= strobe;
            sample_valid_q <= 1'b0;

            if (coef_we) begin
                for (int k = 0; k < NSECT; k++) begin
                    if (int'(coef_addr) == 2 * k)     c1_q[k] <= coef_in;
                    if (int'(coef_addr) == 2 * k + 1) c2_q[k] <= coef_in;
                end
            end

            unique case (state_q)
                Idle: begin
                    if (clear) begin
                        for (int k = 0; k < NSECT; k++) begin
                            d1_q[k] <= '0;
                            d2_q[k] <= '0;
                        end
                    end
                    if (strobe_edge) begin
                        x_q    <= source_in;
                        sect_q <= '0;
                    end
                end
                MacA: acc_q <= (ACCW'(x_q) <<< 9) + ACCW'(prod);
                MacB: acc_q <= acc_q + ACCW'(prod);
                Write: begin
                    d2_q[sect_q] <= d1_q[sect_q];
                    d1_q[sect_q] <= y_sat;
                    x_q          <= y_sat;
                    if (last_sect) begin
                        sample_out_q   <= y_sat;
                        sample_valid_q <= 1'b1;
                    end else begin
                        sect_q <= sect_q + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;

endmodule
